lsu: RTL

Load/store unit for the RISC-V core, directly downstream of the ALU. It takes the effective address computed by the ALU (rs1 + imm), the store operand and the funct3 width code. It then performs one byte, halfword or word access on a single-port, word-wide data memory bus and returns a sign- or zero-extended load result or a store completion. Loads and stores take multiple cycles; the pipeline stalls on `busy`.

---
 rtl/lsu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one byte, halfword or word access per request on a word-wide
// single-port data bus, returning an extended load result or a store completion.
module lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_legal;
  logic        w_aligned;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;

  // Request decode: legality, alignment and lane placement of store data.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    w_wstrb   = 4'b0000;
    w_wdata   = in_wdata;
    if (in_store) begin
      w_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end else begin
      w_legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end
    case (in_funct3[1:0])
      2'b00: begin
        w_aligned = 1'b1;
        w_wstrb   = 4'b0001 << in_addr[1:0];
        w_wdata   = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_aligned = ~in_addr[0];
        w_wstrb   = 4'b0011 << in_addr[1:0];
        w_wdata   = {2{in_wdata[15:0]}};
      end
      default: begin
        w_aligned = (in_addr[1:0] == 2'b00);
        w_wstrb   = 4'b1111;
        w_wdata   = in_wdata;
      end
    endcase
    if (!in_store) begin
      w_wstrb = 4'b0000;
    end
  end

  // Load extraction: move the addressed lane down to bit 0, then extend.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load = {24'h0, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load = {16'h0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_store   <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            busy     <= 1'b1;
            r_store  <= in_store;
            r_funct3 <= in_funct3;
            r_off    <= in_addr[1:0];
            if (w_legal && w_aligned) begin
              r_state   <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= in_store;
              mem_addr  <= in_addr[31:2];
              mem_wstrb <= w_wstrb;
              mem_wdata <= w_wdata;
            end else begin
              // Rejected requests complete immediately without touching the bus.
              r_state   <= S_DONE;
              done      <= 1'b1;
              err       <= 1'b1;
              load_data <= 32'h0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            r_state   <= S_DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            load_data <= r_store ? 32'h0 : w_load;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
